regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file, the successor to the single-write/dual-read CPU register file. It adds configurable read and write port counts, byte-enabled writes and optional write-to-read bypass. It also replaces the old instantaneous reset loop with a sequenced clear engine that the pipeline can also trigger. It sits in the decode/writeback stages and serves dual-issue and debug access.

Parameters:
DW, 32, data width in bits (multiple of 8)
DEPTH, 32, number of registers (power of 2, >=4)
AW, 5, address width, equals log2(DEPTH)
NUM_RD, 2, number of combinational read ports
NUM_WR, 1, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high; starts clear sequence
clr_req  in  1  pulse: request full clear of the register file
busy  out  1  high while the clear sequence runs
we  in  NUM_WR  per-port write enable
wa  in  NUM_WR*AW  write addresses, port i at [i*AW +: AW]
wd  in  NUM_WR*DW  write data, port i at [i*DW +: DW]
wbe  in  NUM_WR*(DW/8)  per-port byte enables
ra  in  NUM_RD*AW  read addresses
rd  out  NUM_RD*DW  read data
dbg_addr  in  AW  debug snoop address
dbg_data  out  DW  debug snoop data, registered

Behaviour:
- Register 0 is hardwired zero: writes to address 0 are discarded; reads of address 0 return 0 on every port, bypass included.
- FSM states: IDLE, CLEAR.
- rst=1 at a clk edge: state<=CLEAR, clr_ptr<=1, dbg_data<=0. rst overrides everything, including an in-progress CLEAR, which restarts at ptr 1.
- CLEAR: each cycle rf[clr_ptr]<=0 and clr_ptr++. After clearing DEPTH-1, go to IDLE. A full clear takes exactly DEPTH-1 cycles after the rst/clr_req edge.
- busy is high in CLEAR, low in IDLE. busy is 1 in the cycle after rst deasserts.
- clr_req in IDLE: next state CLEAR, clr_ptr<=1. clr_req in CLEAR is ignored and does not restart the sequence.
- While busy: all we are ignored (no write lands), and rd and dbg snoop return 0.
- Writes in IDLE:
  - On a clk edge, for each port with we[i]=1 and wa[i]!=0, byte b of rf[wa[i]] is updated iff wbe[i][b].
  - Same address on multiple ports: resolved per byte; the highest-index port with that byte enabled wins.
  - wbe all zero means no change.
- Reads are combinational from the array:
  - BYPASS=1: the returned value merges every same-cycle qualifying write to ra (byte-wise, highest port wins) over the stored value. Write-then-read needs 0 cycles.
  - BYPASS=0: a write is visible from the cycle after the edge.
- dbg_data <= (busy ? 0 : rf[dbg_addr]) each edge; one-cycle latency, no bypass.
- Array contents are not reset other than through the CLEAR sequence. The clear engine is the only mechanism that zeroes storage.

Decomposition:
- Shared package (regfile_pkg): state encoding (ST_IDLE, ST_CLEAR), default DW/DEPTH constants, and a byte-merge function that applies a wbe mask.
- One natural sub-module: regfile_bypass_mux, one instance per read port. It takes stored data, all write ports and ra, and produces the forwarded value. It is generated only when BYPASS=1.
- Clear FSM and array stay in the top module.

Test Plan:
- Reset clear: assert rst 1 cycle after random fills. Require busy=1 for exactly 31 cycles, then 0. Afterwards every register reads 0, and a write presented during busy (wa=5, wd=32'hDEAD_BEEF) is absent.
- Byte write: rf[3]=32'h1122_3344, then write wd=32'hAABB_CCDD with wbe=4'b0101. Next cycle rd=32'h11BB_33DD.
- Bypass (BYPASS=1): we=1, wa=7, wd=32'h0000_00FF with ra0=7 in the same cycle, so rd0=32'h0000_00FF combinationally. With BYPASS=0, rd0 shows the old value until the next cycle.
- Write collision (NUM_WR=2): both ports write address 9. Port0 has wd=32'h1111_1111, wbe=4'b1111. Port1 has wd=32'h2222_2222, wbe=4'b0011. Result is rf[9]=32'h1111_2222.
- Zero register: write wa=0, wd=32'hFFFF_FFFF. All read ports on ra=0 return 0 in the same cycle and the next; dbg_addr=0 gives dbg_data=0.
- Clear mid-sequence: clr_req in IDLE starts CLEAR. A second clr_req 10 cycles in does not extend busy (31 cycles total). An rst at cycle 20 restarts, giving 31 cycles from the rst edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: clear-engine state
// encoding, default geometry and the byte-enable merge helper.
package regfile_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam int DEF_DW    = 32;
   localparam int DEF_DEPTH = 32;

   // The merge helper works on a fixed maximum width; callers cast in and out.
   localparam int MERGE_W  = 256;
   localparam int MERGE_BE = MERGE_W / 8;

   function automatic logic [MERGE_W-1:0] byte_merge(
      input logic [MERGE_W-1:0]  old_val,
      input logic [MERGE_W-1:0]  new_val,
      input logic [MERGE_BE-1:0] be
   );
      logic [MERGE_W-1:0] res;
      res = old_val;
      for (int b = 0; b < MERGE_BE; b++) begin
         if (be[b]) begin
            res[b*8 +: 8] = new_val[b*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Forwards same-cycle writes onto one read port, byte by byte, with the
// highest-index write port taking priority; address 0 always reads zero.
import regfile_pkg::*;

module regfile_bypass_mux #(
   parameter int DW     = DEF_DW,
   parameter int AW     = 5,
   parameter int NUM_WR = 1
) (
   input  logic [DW-1:0]            stored,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*AW-1:0]     wa,
   input  logic [NUM_WR*DW-1:0]     wd,
   input  logic [NUM_WR*(DW/8)-1:0] wbe,
   input  logic [AW-1:0]            ra,
   output logic [DW-1:0]            fwd
);

   localparam int NB = DW / 8;

   always_comb begin
      logic [DW-1:0] merged;
      merged = stored;
      // Applying ports in ascending order lets the highest port win each byte.
      for (int i = 0; i < NUM_WR; i++) begin
         if (we[i] && (wa[i*AW +: AW] == ra) && (ra != '0)) begin
            merged = DW'(byte_merge(MERGE_W'(merged),
                                    MERGE_W'(wd[i*DW +: DW]),
                                    MERGE_BE'(wbe[i*NB +: NB])));
         end
      end
      fwd = (ra == '0) ? '0 : merged;
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with byte-enabled writes, optional write-to-read
// bypass, registered debug snoop and a sequenced clear engine.
import regfile_pkg::*;

module regfile_mp #(
   parameter int DW     = DEF_DW,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int AW     = $clog2(DEPTH),
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 1,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr_req,
   output logic                     busy,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*AW-1:0]     wa,
   input  logic [NUM_WR*DW-1:0]     wd,
   input  logic [NUM_WR*(DW/8)-1:0] wbe,
   input  logic [NUM_RD*AW-1:0]     ra,
   output logic [NUM_RD*DW-1:0]     rd,
   input  logic [AW-1:0]            dbg_addr,
   output logic [DW-1:0]            dbg_data
);

   localparam int NB = DW / 8;

   state_t        state;
   logic [AW-1:0] clr_ptr;
   logic [DW-1:0] rf [DEPTH];

   assign busy = (state == ST_CLEAR);

   // Clear engine; register 0 is never stored so the sweep starts at 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_CLEAR;
         clr_ptr  <= AW'(1);
         dbg_data <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               dbg_data <= (dbg_addr == '0) ? '0 : rf[dbg_addr];
               if (clr_req) begin
                  state   <= ST_CLEAR;
                  clr_ptr <= AW'(1);
               end
            end
            ST_CLEAR: begin
               dbg_data <= '0;
               clr_ptr  <= clr_ptr + AW'(1);
               if (clr_ptr == AW'(DEPTH - 1)) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state    <= ST_IDLE;
               dbg_data <= '0;
            end
         endcase
      end
   end

   // Later non-blocking byte writes override earlier ones, so the
   // highest-index port wins a byte collision.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == ST_CLEAR) begin
            rf[clr_ptr] <= '0;
         end else begin
            for (int i = 0; i < NUM_WR; i++) begin
               for (int b = 0; b < NB; b++) begin
                  if (we[i] && (wa[i*AW +: AW] != '0) && wbe[i*NB + b]) begin
                     rf[wa[i*AW +: AW]][b*8 +: 8] <= wd[i*DW + b*8 +: 8];
                  end
               end
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [AW-1:0] addr;
         logic [DW-1:0] stored;
         logic [DW-1:0] value;

         assign addr   = ra[gi*AW +: AW];
         assign stored = (addr == '0) ? '0 : rf[addr];

         if (BYPASS != 0) begin : g_byp
            regfile_bypass_mux #(
               .DW     (DW),
               .AW     (AW),
               .NUM_WR (NUM_WR)
            ) u_bypass (
               .stored (stored),
               .we     (we),
               .wa     (wa),
               .wd     (wd),
               .wbe    (wbe),
               .ra     (addr),
               .fwd    (value)
            );
         end else begin : g_nobyp
            assign value = stored;
         end

         assign rd[gi*DW +: DW] = busy ? '0 : value;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing two-write-port instance and a plain
// single-write-port instance share stimulus and are checked against a model.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr_req;
   logic [1:0]  we;
   logic [9:0]  wa;
   logic [63:0] wd;
   logic [7:0]  wbe;
   logic [9:0]  ra;
   logic [4:0]  dbg_addr;

   logic        busy_a, busy_b;
   logic [63:0] rd_a, rd_b;
   logic [31:0] dbg_a, dbg_b;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_a [32];
   logic [31:0] m_b [32];
   int          clr_left = 0;
   logic [31:0] mdbg_a = '0;
   logic [31:0] mdbg_b = '0;

   always #5 clk = ~clk;

   regfile_mp #(.DW(32), .DEPTH(32), .AW(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_a (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a),
      .we(we), .wa(wa), .wd(wd), .wbe(wbe), .ra(ra), .rd(rd_a),
      .dbg_addr(dbg_addr), .dbg_data(dbg_a)
   );

   regfile_mp #(.DW(32), .DEPTH(32), .AW(5), .NUM_RD(2), .NUM_WR(1), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b),
      .we(we[0]), .wa(wa[4:0]), .wd(wd[31:0]), .wbe(wbe[3:0]), .ra(ra), .rd(rd_b),
      .dbg_addr(dbg_addr), .dbg_data(dbg_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference read: zero while clearing or at address 0; otherwise stored
   // value with this cycle's enabled writes (later ports last) laid on top.
   function automatic logic [31:0] model_read(input bit byp, input logic [4:0] a);
      logic [31:0] v;
      if (clr_left > 0 || a == 5'd0) return 32'd0;
      if (!byp) return m_b[a];
      v = m_a[a];
      for (int p = 0; p < 2; p++)
         if (we[p] && wa[p*5 +: 5] == a)
            for (int b = 0; b < 4; b++)
               if (wbe[p*4 + b]) v[b*8 +: 8] = wd[p*32 + b*8 +: 8];
      return v;
   endfunction

   task automatic zero_model();
      for (int i = 0; i < 32; i++) begin
         m_a[i] = '0;
         m_b[i] = '0;
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         clr_left = 31;
         mdbg_a   = '0;
         mdbg_b   = '0;
         zero_model();
      end else if (clr_left > 0) begin
         clr_left--;
         mdbg_a = '0;
         mdbg_b = '0;
      end else begin
         mdbg_a = m_a[dbg_addr];
         mdbg_b = m_b[dbg_addr];
         for (int p = 0; p < 2; p++)
            if (we[p] && wa[p*5 +: 5] != 5'd0)
               for (int b = 0; b < 4; b++)
                  if (wbe[p*4 + b]) begin
                     m_a[wa[p*5 +: 5]][b*8 +: 8] = wd[p*32 + b*8 +: 8];
                     if (p == 0) m_b[wa[4:0]][b*8 +: 8] = wd[b*8 +: 8];
                  end
         if (clr_req) begin
            clr_left = 31;
            zero_model();
         end
      end
   endtask

   task automatic tick();
      #1;
      for (int p = 0; p < 2; p++) begin
         check($sformatf("rd_a%0d", p), rd_a[p*32 +: 32], model_read(1'b1, ra[p*5 +: 5]));
         check($sformatf("rd_b%0d", p), rd_b[p*32 +: 32], model_read(1'b0, ra[p*5 +: 5]));
      end
      @(posedge clk);
      model_edge();
      #1;
      check("busy_a", busy_a, 64'(clr_left > 0));
      check("busy_b", busy_b, 64'(clr_left > 0));
      check("dbg_a", dbg_a, mdbg_a);
      check("dbg_b", dbg_b, mdbg_b);
   endtask

   initial begin
      int n;
      rst = 1'b1; clr_req = 1'b0; we = '0; wa = '0; wd = '0; wbe = '0; ra = '0; dbg_addr = '0;
      @(posedge clk);
      model_edge();
      #1;
      check("busy_after_rst", busy_a, 64'd1);
      rst = 1'b0;
      n = 0;
      while (busy_a && n < 100) begin n++; tick(); end
      check("init_clear_cycles", n, 64'd31);

      // Random fill with frequent read-after-write on the same address.
      repeat (60) begin
         we = 2'($urandom); wa = 10'($urandom); wd = {$urandom, $urandom};
         wbe = 8'($urandom); dbg_addr = 5'($urandom);
         ra = ($urandom_range(0, 1) == 1) ? wa : 10'($urandom);
         tick();
      end

      // Reset clear with a write held during busy.
      we = '0; rst = 1'b1;
      tick();
      rst = 1'b0;
      we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEAD_BEEF}; wbe = 8'h0F;
      n = 0;
      while (busy_a && n < 100) begin n++; tick(); end
      check("rst_busy_cycles", n, 64'd31);
      we = '0;
      for (int a = 0; a < 32; a++) begin
         ra = {5'(31 - a), 5'(a)};
         #1;
         check($sformatf("clr_a_r%0d", a), rd_a, 64'd0);
         check($sformatf("clr_b_r%0d", a), rd_b, 64'd0);
      end
      ra = {5'd5, 5'd5}; dbg_addr = 5'd5;
      tick();
      tick();
      check("busy_write_absent", dbg_a, 64'd0);

      // Byte-enabled write.
      we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'd0, 32'h1122_3344}; wbe = 8'h0F;
      tick();
      wd = {32'd0, 32'hAABB_CCDD}; wbe = 8'h05;
      tick();
      we = '0; ra = {5'd0, 5'd3};
      #1;
      check("byte_wr_a", rd_a[31:0], 64'h11BB_33DD);
      check("byte_wr_b", rd_b[31:0], 64'h11BB_33DD);
      tick();

      // Bypass versus registered visibility.
      we = 2'b01; wa = {5'd0, 5'd7}; wd = {32'd0, 32'h1234_5678}; wbe = 8'h0F;
      tick();
      wd = {32'd0, 32'h0000_00FF}; ra = {5'd0, 5'd7};
      #1;
      check("bypass_a", rd_a[31:0], 64'h0000_00FF);
      check("nobypass_old_b", rd_b[31:0], 64'h1234_5678);
      tick();
      we = '0;
      #1;
      check("nobypass_new_b", rd_b[31:0], 64'h0000_00FF);
      tick();

      // Two ports colliding on one address.
      we = 2'b11; wa = {5'd9, 5'd9}; wd = {32'h2222_2222, 32'h1111_1111}; wbe = 8'h3F;
      ra = {5'd9, 5'd9};
      #1;
      check("collide_bypass", rd_a[31:0], 64'h1111_2222);
      tick();
      we = '0;
      #1;
      check("collide_a", rd_a[31:0], 64'h1111_2222);
      check("collide_b", rd_b[31:0], 64'h1111_1111);
      tick();

      // Zero register.
      we = 2'b11; wa = '0; wd = '1; wbe = '1; ra = '0; dbg_addr = 5'd0;
      #1;
      check("zero_same_a", rd_a, 64'd0);
      check("zero_same_b", rd_b, 64'd0);
      tick();
      we = '0;
      tick();
      check("zero_next_a", rd_a, 64'd0);
      check("zero_dbg_a", dbg_a, 64'd0);
      check("zero_dbg_b", dbg_b, 64'd0);

      // clr_req during CLEAR must not extend it.
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      n = 0;
      while (busy_a && n < 100) begin
         n++;
         clr_req = (n == 10);
         tick();
         clr_req = 1'b0;
      end
      check("clr_req_cycles", n, 64'd31);

      // rst mid-clear restarts the full sweep.
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n = 0;
      while (busy_a && n < 100) begin n++; tick(); end
      check("rst_restart_cycles", n, 64'd31);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
